// File: rtl/seq_div.sv
// Iterative radix-2 restoring divider: quotient/remainder in 33 cycles.
// Optional DIV_ZERO_FAST_EN: one-cycle divide-by-zero path with dz flag.
module seq_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] shang,
`ifdef DIV_ZERO_FAST_EN
    output logic [WIDTH-1:0] yushu,
    output logic             dz
`else
    output logic [WIDTH-1:0] yushu
`endif
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH:0]   r_rem;
    logic [CW-1:0]    r_cnt;
    logic             r_sgn_q;
    logic             r_sgn_r;
    logic [WIDTH-1:0] r_shang;
    logic [WIDTH-1:0] r_yushu;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH+1:0] w_shift;
    logic [WIDTH+1:0] w_trial;
    logic             w_ge;
    logic             w_last;

`ifdef DIV_ZERO_FAST_EN
    logic r_dz;
    logic r_dz_pend;
    logic w_zero;

    assign w_zero = (b == '0);
    assign dz     = r_dz;
`endif

    assign w_a_mag = (sign && a[WIDTH-1]) ? -a : a;
    assign w_b_mag = (sign && b[WIDTH-1]) ? -b : b;

    // Borrow out of the wide subtract means the trial went negative.
    assign w_shift = {r_rem, r_dvd[WIDTH-1]};
    assign w_trial = w_shift - {2'b00, r_dvs};
    assign w_ge    = ~w_trial[WIDTH+1];
    assign w_last  = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
`ifdef DIV_ZERO_FAST_EN
                    w_state_nxt = w_zero ? S_FIX : S_CALC;
`else
                    w_state_nxt = S_CALC;
`endif
                end
            end
            S_CALC: begin
                if (w_last) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dvd     <= '0;
            r_dvs     <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_sgn_q   <= 1'b0;
            r_sgn_r   <= 1'b0;
            r_shang   <= '0;
            r_yushu   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef DIV_ZERO_FAST_EN
            r_dz      <= 1'b0;
            r_dz_pend <= 1'b0;
`endif
        end else begin
            r_busy <= (w_state_nxt != S_IDLE);
            r_done <= (r_state == S_FIX);
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sgn_q <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_sgn_r <= sign & a[WIDTH-1];
                        r_dvd   <= w_a_mag;
                        r_dvs   <= w_b_mag;
                        r_rem   <= '0;
                        r_cnt   <= '0;
`ifdef DIV_ZERO_FAST_EN
                        r_dz      <= 1'b0;
                        r_dz_pend <= w_zero;
                        // Preload FIX with the raw divide-by-zero result.
                        if (w_zero) begin
                            r_dvd   <= '1;
                            r_rem   <= {1'b0, a};
                            r_sgn_q <= 1'b0;
                            r_sgn_r <= 1'b0;
                        end
`endif
                    end
                end
                S_CALC: begin
                    r_dvd <= {r_dvd[WIDTH-2:0], w_ge};
                    r_rem <= w_ge ? w_trial[WIDTH:0] : w_shift[WIDTH:0];
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FIX: begin
                    r_shang <= r_sgn_q ? -r_dvd : r_dvd;
                    r_yushu <= r_sgn_r ? -r_rem[WIDTH-1:0]
                                       : r_rem[WIDTH-1:0];
`ifdef DIV_ZERO_FAST_EN
                    r_dz    <= r_dz_pend;
`endif
                end
                default: begin
                end
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign shang = r_shang;
    assign yushu = r_yushu;

endmodule

// File: tb/tb_seq_div.sv
// Randomized and directed checks of seq_div against an arithmetic model.
// Build with DIV_ZERO_FAST_EN to cover the fast divide-by-zero path.
module tb_seq_div;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        sign;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] shang;
    logic [31:0] yushu;
`ifdef DIV_ZERO_FAST_EN
    logic        dz;
`endif

    int total = 0;
    int bad   = 0;

    seq_div #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .sign  (sign),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .shang (shang),
`ifdef DIV_ZERO_FAST_EN
        .yushu (yushu),
        .dz    (dz)
`else
        .yushu (yushu)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [31:0] ma, input logic [31:0] mb,
                                  input logic ms, output logic [31:0] q,
                                  output logic [31:0] r);
        longint sa;
        longint sb;
        longint qq;
        longint rr;
        if (mb == 0) begin
            r = ma;
`ifdef DIV_ZERO_FAST_EN
            q = 32'hFFFF_FFFF;
`else
            q = (ms && ma[31]) ? 32'd1 : 32'hFFFF_FFFF;
`endif
        end else if (!ms) begin
            q = ma / mb;
            r = ma % mb;
        end else begin
            sa = longint'($signed(ma));
            sb = longint'($signed(mb));
            qq = sa / sb;
            rr = sa % sb;
            q  = qq[31:0];
            r  = rr[31:0];
        end
    endfunction

    function automatic int exp_lat(input logic [31:0] mb);
`ifdef DIV_ZERO_FAST_EN
        return (mb == 0) ? 1 : 33;
`else
        return 33;
`endif
    endfunction

    // Enter with inputs changeable (away from an edge); returns #1 after done.
    task automatic op(input string tag, input logic [31:0] ta,
                      input logic [31:0] tb, input logic ts);
        int lat;
        int bcnt;
        int both;
        logic [31:0] eq;
        logic [31:0] er;
        start = 1'b1;
        a     = ta;
        b     = tb;
        sign  = ts;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        sign  = 1'($urandom);
        lat   = -1;
        bcnt  = int'(busy);
        both  = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (busy && done) both++;
            if (done) begin
                lat = k;
                break;
            end
            if (busy) bcnt++;
        end
        model(ta, tb, ts, eq, er);
        chk({tag, "_lat"}, lat, exp_lat(tb));
        chk({tag, "_busy"}, bcnt, exp_lat(tb));
        chk({tag, "_q"}, shang, eq);
        chk({tag, "_r"}, yushu, er);
        chk({tag, "_ovl"}, both, 0);
`ifdef DIV_ZERO_FAST_EN
        chk({tag, "_dz"}, 32'(dz), 32'(tb == 0));
`endif
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        int lat;
        reset = 1'b1;
        start = 1'b0;
        sign  = 1'b0;
        a     = '0;
        b     = '0;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_q", shang, 0);
        chk("rst_r", yushu, 0);
`ifdef DIV_ZERO_FAST_EN
        chk("rst_dz", 32'(dz), 0);
`endif
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        op("u100_7", 32'd100, 32'd7, 1'b0);
        op("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
        op("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1);
        op("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        op("u_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0);
        op("u_big", 32'h8000_0000, 32'h8000_0001, 1'b0);
        op("dz_u", 32'h1234_5678, 32'd0, 1'b0);
        op("dz_sn", 32'h8765_4321, 32'd0, 1'b1);
        op("dz_sp", 32'h1234_5678, 32'd0, 1'b1);
        op("s_m8_m3", 32'hFFFF_FFF8, 32'hFFFF_FFFD, 1'b1);
        op("u_small", 32'd3, 32'd10, 1'b0);

        // A second start while busy must be ignored.
        start = 1'b1;
        a     = 32'd1000;
        b     = 32'd10;
        sign  = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        a     = 32'd55;
        b     = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = -1;
        for (int k = 6; k <= 45; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        chk("ign_lat", lat, 33);
        chk("ign_q", shang, 32'd100);
        chk("ign_r", yushu, 32'd0);

        // Asynchronous reset mid-operation.
        @(negedge clk);
        start = 1'b1;
        a     = 32'd999;
        b     = 32'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_q", shang, 0);
        chk("arst_r", yushu, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        op("post_rst", 32'd999, 32'd4, 1'b0);

        for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 4))
                0: rb = 32'd0;
                1: rb = rb >> $urandom_range(8, 31);
                2: ra = {ra[31], 31'(ra >> $urandom_range(0, 30))};
                default: ;
            endcase
            op($sformatf("rnd%0d", i), ra, rb, 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
